// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for the T flip-flop counter controller: FSM encoding and default width.
package tff_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int ST_W          = 2;

  // Only two encodings are legal; the other two recover to ST_IDLE.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_e;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop cell: toggles when t is high, synchronous active-low reset to 0.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_counter_ctrl.sv
// Sequences a bank of T flip-flop cells as a programmable up/down modulo counter with
// start/stop control, one-shot or periodic operation and terminal-count/done pulses.
module tff_counter_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_up,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done,
  output state_e           dbg_state
);

  // Handshake: start is a level sampled only while idle, stop a level sampled only while
  // running; neither needs to be held beyond the edge at which it is seen.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_up_q, mode_up_d;
  logic             periodic_q, periodic_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] up_t, dn_t, step_t;
  logic             carry_up, carry_dn;

  logic [WIDTH-1:0] start_val, end_val;
  logic [WIDTH-1:0] start_val_in, end_val_in;

  // Running config comes from the latched copies; the incoming copies are only used on start.
  assign start_val    = mode_up_q ? '0 : limit_q;
  assign end_val      = mode_up_q ? limit_q : '0;
  assign start_val_in = mode_up ? '0 : limit;
  assign end_val_in   = mode_up ? limit : '0;

  // Toggle masks for +1 / -1: a bit flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    carry_up = 1'b1;
    carry_dn = 1'b1;
    up_t     = '0;
    dn_t     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i]  = carry_up;
      dn_t[i]  = carry_dn;
      carry_up = carry_up & q_w[i];
      carry_dn = carry_dn & ~q_w[i];
    end
  end

  assign step_t = mode_up_q ? up_t : dn_t;

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    mode_up_d  = mode_up_q;
    periodic_d = periodic_q;
    t_vec      = '0;
    tc_d       = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          limit_d    = limit;
          mode_up_d  = mode_up;
          periodic_d = periodic;
          t_vec      = q_w ^ start_val_in;
          tc_d       = (start_val_in == end_val_in);
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (q_w != end_val) begin
          t_vec = step_t;
          tc_d  = ((q_w ^ step_t) == end_val);
        end else if (periodic_q) begin
          t_vec = q_w ^ start_val;
          tc_d  = (start_val == end_val);
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      limit_q    <= '0;
      mode_up_q  <= 1'b0;
      periodic_q <= 1'b0;
      tc_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      mode_up_q  <= mode_up_d;
      periodic_q <= periodic_d;
      tc_q       <= tc_d;
      done_q     <= done_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t_vec[g]),
      .q     (q_w[g])
    );
  end

  assign count     = q_w;
  assign busy      = (state_q == ST_RUN);
  assign tc_pulse  = tc_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
